// File: rtl/mvm_pkg.sv
// Shared types and defaults for the mat_vec_mult load sequencer.
// The state enum is also exported on the sequencer's debug port.
package mvm_pkg;

  parameter int DEF_DATA_WIDTH = 8;
  parameter int DEF_DEPTH      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    REQ     = 3'd2,
    WAIT    = 3'd3,
    COMPUTE = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } mvm_seq_state_t;

  // One memory word carries a full matrix row (or the whole vector).
  function automatic int word_bits(input int data_width, input int depth);
    return data_width * depth;
  endfunction

endpackage

// File: rtl/mvm_watchdog.sv
// Cycle watchdog: load clears the count, en advances it, expired flags the
// last permitted cycle so the owner can leave on the following edge.
module mvm_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mvm_load_sequencer.sv
// Loads DEPTH matrix rows plus one vector word into mat_vec_mult, then waits
// for mac_done. Define MVM_SEQ_TIMEOUT_EN to add the REQ/WAIT/COMPUTE watchdog.
module mvm_load_sequencer
  import mvm_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [ADDR_W-1:0]                     base_addr,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [ADDR_W-1:0]                     avm_address,
  output logic                                  avm_read,
  input  logic [word_bits(DATA_WIDTH, DEPTH)-1:0] avm_readdata,
  input  logic                                  avm_readdatavalid,
  input  logic                                  avm_waitrequest,
  output logic                                  mac_clr,
  output logic                                  a_wren,
  output logic                                  b_wren,
  input  logic                                  mac_done,
  output mvm_seq_state_t                        dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);

  mvm_seq_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              wd_expired;

  // Data is steered straight from the bus into the FIFOs, never through here.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;

`ifdef MVM_SEQ_TIMEOUT_EN
  logic wd_load;
  logic wd_en;
  // Restart on every cycle whose successor is a fresh REQ or COMPUTE.
  assign wd_load = (state == CLEAR) || ((state == WAIT) && avm_readdatavalid);
  assign wd_en   = (state == REQ) || (state == WAIT) || (state == COMPUTE);

  mvm_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  // Avalon read handshake: a request transfers on the edge where avm_read=1
  // and avm_waitrequest=0; address and read stay frozen until then. Exactly
  // one read is outstanding, answered by a single readdatavalid in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      mac_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state   <= CLEAR;
            base    <= base_addr;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state       <= REQ;
          avm_address <= base;
          avm_read    <= 1'b1;
        end
        REQ: begin
          if (wd_expired) begin
            state    <= ERROR;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else if (!avm_waitrequest) begin
            state    <= WAIT;
            avm_read <= 1'b0;
          end
        end
        WAIT: begin
          if (wd_expired) begin
            state <= ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (avm_readdatavalid) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state <= COMPUTE;
            end else begin
              state       <= REQ;
              avm_address <= base + ADDR_W'(cnt) + ADDR_W'(1);
              avm_read    <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (wd_expired) begin
            state <= ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (mac_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_wren    = (state == WAIT) && avm_readdatavalid && !wd_expired && (cnt < LAST);
  assign b_wren    = (state == WAIT) && avm_readdatavalid && !wd_expired && (cnt == LAST);
  assign dbg_state = state;

endmodule

// File: tb/tb_mvm_load_sequencer.sv
// Directed bench for mvm_load_sequencer with a 1-cycle-latency memory model
// that can stall one address or drop the response to one address.
module tb_mvm_load_sequencer;
  import mvm_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 32;
  localparam int TO = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              busy, done, err;
  logic [AW-1:0]     avm_address;
  logic              avm_read;
  logic [DW*DP-1:0]  avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;
  logic              mac_clr, a_wren, b_wren;
  logic              mac_done;
  mvm_seq_state_t    dbg_state;

  mvm_load_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .mac_clr(mac_clr), .a_wren(a_wren), .b_wren(b_wren), .mac_done(mac_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // memory model controls
  logic [AW-1:0] stall_addr  = '0;
  int            stall_left  = 0;
  logic          drop_en     = 1'b0;
  logic [AW-1:0] drop_addr   = '0;
  logic          force_valid = 1'b0;
  logic          rsp_acc;
  logic [AW-1:0] rsp_addr;

  // monitor state
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_q[$];
  int            n_a = 0, n_b = 0, n_clr = 0, n_rd = 0, n_watch = 0;
  int            n_viol = 0, n_instab = 0;
  logic [AW-1:0] watch_addr = 32'hDEAD_BEEF;
  logic [AW-1:0] last_acc = '0;
  logic [AW-1:0] b_addr = '0;
  logic          prev_pending = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // Memory: answer an accepted read one cycle later; stall/drop on request.
  always @(posedge clk) begin
    rsp_acc  = rst_n && avm_read && !avm_waitrequest;
    rsp_addr = avm_address;
    #1;
    avm_readdatavalid = force_valid || (rsp_acc && !(drop_en && rsp_addr == drop_addr));
    avm_readdata      = {8{rsp_addr[7:0]}};
    if (avm_read && stall_left > 0 && avm_address == stall_addr) begin
      avm_waitrequest = 1'b1;
      stall_left      = stall_left - 1;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (a_wren) n_a++;
    if (b_wren) begin n_b++; b_addr = last_acc; end
    if (mac_clr) n_clr++;
    if (avm_read) n_rd++;
    if (avm_read && avm_address == watch_addr) n_watch++;
    if ((a_wren && b_wren) || (mac_clr && (a_wren || b_wren)) ||
        ((a_wren || b_wren) && dbg_state != WAIT)) n_viol++;
    if (rst_n && prev_pending && (!avm_read || avm_address != prev_addr)) n_instab++;
    prev_pending = rst_n && avm_read && avm_waitrequest;
    prev_addr    = avm_address;
    if (rst_n && avm_read && !avm_waitrequest) begin
      obs_q.push_back(avm_address);
      last_acc = avm_address;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    n_a = 0; n_b = 0; n_clr = 0; n_rd = 0; n_watch = 0;
  endtask

  task automatic start_job(input logic [AW-1:0] b);
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_state(input mvm_seq_state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == s) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic pulse_mac_done();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
    n_cmp++; if ({busy, done, err, avm_read, mac_clr, a_wren, b_wren} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs got %b want 0000000", {busy, done, err, avm_read, mac_clr, a_wren, b_wren}); end
    n_cmp++; if (avm_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", avm_address); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    bit bad;
    clear_mon();
    for (int i = 0; i <= DP; i++) exp_q.push_back(AW'(i));
    start_job(32'h0);
    n_cmp++; if ({dbg_state == CLEAR, mac_clr, busy} !== 3'b111) begin
      n_fail++; $display("FAIL basic_clear got st=%0d clr=%b busy=%b want st=%0d clr=1 busy=1", dbg_state, mac_clr, busy, CLEAR); end
    tick();
    n_cmp++; if ({avm_read, mac_clr} !== 2'b10 || avm_address !== 32'h0) begin
      n_fail++; $display("FAIL basic_first_req got rd=%b clr=%b addr=%h want rd=1 clr=0 addr=0", avm_read, mac_clr, avm_address); end
    wait_state(COMPUTE, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_reach_compute got timeout want COMPUTE"); end
    n_cmp++; if (n_clr !== 1) begin n_fail++; $display("FAIL basic_clr_count got %0d want 1", n_clr); end
    n_cmp++; if (n_a !== DP || n_b !== 1) begin n_fail++; $display("FAIL basic_wren got a=%0d b=%0d want a=%0d b=1", n_a, n_b, DP); end
    n_cmp++; if (b_addr !== 32'h8) begin n_fail++; $display("FAIL basic_b_addr got %h want 8", b_addr); end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_cmp++; if (bad) begin n_fail++; $display("FAIL basic_addr_seq got %p want %p", obs_q, exp_q); end
    pulse_mac_done();
    n_cmp++; if (dbg_state !== DONE || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done got st=%0d done=%b busy=%b want st=%0d done=1 busy=0", dbg_state, done, busy, DONE); end
  endtask

  task automatic test_wait_stall();
    bit ok;
    bit bad;
    clear_mon();
    for (int i = 0; i <= DP; i++) exp_q.push_back(AW'(i));
    watch_addr = 32'h4;
    stall_addr = 32'h4;
    stall_left = 3;
    start_job(32'h0);
    wait_state(COMPUTE, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_reach_compute got timeout want COMPUTE"); end
    n_cmp++; if (n_watch !== 4) begin n_fail++; $display("FAIL stall_hold_cycles got %0d want 4", n_watch); end
    n_cmp++; if (n_rd !== 12) begin n_fail++; $display("FAIL stall_read_cycles got %0d want 12", n_rd); end
    n_cmp++; if (n_a + n_b !== 9 || n_b !== 1) begin n_fail++; $display("FAIL stall_wren got a=%0d b=%0d want a=8 b=1", n_a, n_b); end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_cmp++; if (bad) begin n_fail++; $display("FAIL stall_addr_seq got %p want %p", obs_q, exp_q); end
    watch_addr = 32'hDEAD_BEEF;
    pulse_mac_done();
  endtask

  task automatic test_wrap();
    bit ok;
    bit bad;
    logic [AW-1:0] a;
    clear_mon();
    a = 32'hFFFF_FFFC;
    for (int i = 0; i <= DP; i++) begin exp_q.push_back(a); a = a + 32'h1; end
    start_job(32'hFFFF_FFFC);
    wait_state(COMPUTE, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_reach_compute got timeout want COMPUTE"); end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_cmp++; if (bad) begin n_fail++; $display("FAIL wrap_addr_seq got %p want %p", obs_q, exp_q); end
    n_cmp++; if (b_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_b_addr got %h want 4", b_addr); end
    pulse_mac_done();
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    bit bad;
    clear_mon();
    drop_en   = 1'b1;
    drop_addr = 32'h5;
    start_job(32'h0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dbg_state == WAIT && avm_address == 32'h5) begin ok = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_reach_wait5 got timeout want WAIT@5"); end
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (dbg_state !== IDLE || {busy, done, err, avm_read, mac_clr, a_wren, b_wren} !== 7'b0 || avm_address !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outs got st=%0d outs=%b addr=%h want st=%0d outs=0 addr=0",
                         dbg_state, {busy, done, err, avm_read, mac_clr, a_wren, b_wren}, avm_address, IDLE); end
    rst_n   = 1'b1;
    drop_en = 1'b0;
    n_a = 0;
    @(negedge clk);
    force_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_wren !== 1'b0 || b_wren !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stray_wren got a=%b b=%b want a=0 b=0", a_wren, b_wren); end
    force_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (dbg_state !== IDLE || n_a !== 0) begin
      n_fail++; $display("FAIL midrst_stray_idle got st=%0d a=%0d want st=%0d a=0", dbg_state, n_a, IDLE); end
    clear_mon();
    for (int i = 0; i <= DP; i++) exp_q.push_back(AW'(i));
    start_job(32'h0);
    wait_state(COMPUTE, 100, ok);
    bad = !ok || (obs_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_cmp++; if (bad || n_a !== DP || n_b !== 1) begin
      n_fail++; $display("FAIL midrst_clean_job got addrs=%p a=%0d b=%0d want 0..8 a=8 b=1", obs_q, n_a, n_b); end
    pulse_mac_done();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    start_job(32'h0);
    wait_state(COMPUTE, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_reach_compute got timeout want COMPUTE"); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (dbg_state !== COMPUTE || busy !== 1'b1 || n_clr !== 1) begin
      n_fail++; $display("FAIL b2b_start_ignored got st=%0d busy=%b clr=%0d want st=%0d busy=1 clr=1", dbg_state, busy, n_clr, COMPUTE); end
    pulse_mac_done();
    n_cmp++; if (dbg_state !== DONE || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done1 got st=%0d done=%b want st=%0d done=1", dbg_state, done, DONE); end
    start = 1'b1;
    tick();
    n_cmp++; if (dbg_state !== CLEAR || done !== 1'b0 || mac_clr !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got st=%0d done=%b clr=%b busy=%b want st=%0d done=0 clr=1 busy=1",
                         dbg_state, done, mac_clr, busy, CLEAR); end
    wait_state(COMPUTE, 100, ok);
    pulse_mac_done();
    n_cmp++; if (!ok || dbg_state !== DONE || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done2 got st=%0d done=%b want st=%0d done=1", dbg_state, done, DONE); end
    tick();
    n_cmp++; if (dbg_state !== CLEAR || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_held_start got st=%0d done=%b want st=%0d done=0", dbg_state, done, CLEAR); end
    start = 1'b0;
    wait_state(COMPUTE, 100, ok);
    pulse_mac_done();
    n_cmp++; if (!ok || dbg_state !== DONE || n_clr !== 3) begin
      n_fail++; $display("FAIL b2b_final got st=%0d clr=%0d want st=%0d clr=3", dbg_state, n_clr, DONE); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    clear_mon();
    drop_en   = 1'b1;
    drop_addr = 32'h2;
    start_job(32'h0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dbg_state == REQ && avm_address == 32'h2) begin ok = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_reach_req2 got timeout want REQ@2"); end
`ifdef MVM_SEQ_TIMEOUT_EN
    cyc = 0;
    while (dbg_state != ERROR && cyc < 100) begin tick(); cyc++; end
    n_cmp++; if (cyc !== TO) begin n_fail++; $display("FAIL timeout_cycles got %0d want %0d", cyc, TO); end
    n_cmp++; if ({err, avm_read, busy, done} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_outs got err/rd/busy/done=%b want 1000", {err, avm_read, busy, done}); end
    n_cmp++; if (n_a !== 2 || n_b !== 0) begin n_fail++; $display("FAIL timeout_wren got a=%0d b=%0d want a=2 b=0", n_a, n_b); end
`else
    cyc = 0;
    for (int i = 0; i < 4 * TO; i++) begin tick(); cyc++; end
    n_cmp++; if (dbg_state !== WAIT || {busy, err, avm_read} !== 3'b100) begin
      n_fail++; $display("FAIL no_timeout_hang got st=%0d busy/err/rd=%b after %0d cycles want st=%0d busy/err/rd=100",
                         dbg_state, {busy, err, avm_read}, cyc, WAIT); end
    n_cmp++; if (n_a !== 2 || n_b !== 0) begin n_fail++; $display("FAIL no_timeout_wren got a=%0d b=%0d want a=2 b=0", n_a, n_b); end
`endif
    drop_en = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic test_invariants();
    n_cmp++; if (n_viol !== 0) begin n_fail++; $display("FAIL wren_exclusive got %0d violations want 0", n_viol); end
    n_cmp++; if (n_instab !== 0) begin n_fail++; $display("FAIL req_stable got %0d changes want 0", n_instab); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n             = 1'b0;
    start             = 1'b0;
    base_addr         = '0;
    mac_done          = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    test_reset();
    test_basic();
    test_wait_stall();
    test_wrap();
    test_reset_mid_job();
    test_back_to_back();
    test_timeout();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_load_sequencer.md
Name: mvm_load_sequencer

Overview:
- Controller between the mem_wrapper read port (Avalon-MM style) and mat_vec_mult.
- On start: clears the MAC, reads DEPTH matrix rows then one vector word from consecutive word addresses, and steers each returned word into the A FIFOs or the B FIFO.
- Then waits for the MAC to finish and reports done; replaces ad-hoc top-level sequencing with a restartable block that has a base address.

Parameters:
- DATA_WIDTH, 8, element width; one memory word = DEPTH*DATA_WIDTH bits.
- DEPTH, 8, matrix rows/columns; DEPTH+1 reads per job.
- ADDR_W, 32, memory address width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset synchronous active-low.
- start  in  1  job request; sampled in IDLE/DONE/ERROR only.
- base_addr  in  ADDR_W  word address of row 0; captured on the accepted start.
- busy  out  1  job in progress (states CLEAR..COMPUTE).
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERROR.
- avm_address  out  ADDR_W  registered read address.
- avm_read  out  1  read request.
- avm_readdata  in  DEPTH*DATA_WIDTH  returned word.
- avm_readdatavalid  in  1  readdata valid.
- avm_waitrequest  in  1  slave stall.
- mac_clr  out  1  one-cycle clear to mat_vec_mult.
- a_wren  out  1  push avm_readdata into the A FIFOs (row data).
- b_wren  out  1  push avm_readdata into the B FIFO (vector).
- mac_done  in  1  mat_vec_mult done.

Behaviour:

Reset:
- Synchronous: on a clk edge with rst_n=0, state goes to IDLE and cnt goes to 0.
- All outputs are 0, including avm_address.
- Reset mid-job abandons any outstanding read. A later readdatavalid arriving in IDLE is ignored.

State machine (states IDLE, CLEAR, REQ, WAIT, COMPUTE, DONE, ERROR):
- IDLE/DONE/ERROR: start=1 -> CLEAR. base_addr is latched, cnt<=0, done/err are cleared.
- CLEAR: mac_clr=1 for exactly one cycle -> REQ. avm_address<=base.
- REQ:
  - avm_read=1, with avm_address = base+cnt held stable.
  - While avm_waitrequest=1, stay in REQ.
  - On the cycle avm_waitrequest=0, the request is accepted -> WAIT. avm_read drops on the next cycle.
  - Only one read is outstanding at a time.
- WAIT:
  - On avm_readdatavalid=1, assert a_wren (if cnt<DEPTH) or b_wren (if cnt==DEPTH) combinationally in the same cycle, and cnt<=cnt+1.
  - If cnt==DEPTH -> COMPUTE. Otherwise -> REQ with avm_address<=base+cnt+1.
- COMPUTE: wait for mac_done=1 -> DONE.
- DONE: done=1 until the next start.
- ERROR: err=1 until the next start. Exists only with the optional feature.

Rules and boundary conditions:
- Memory read latency must be at least 1 cycle after acceptance. readdatavalid outside WAIT is ignored and never produces a write enable.
- a_wren and b_wren are mutually exclusive and never high outside WAIT. mac_clr is never coincident with either.
- start while busy=1 is ignored. start held high in DONE restarts every time DONE is entered (back-to-back jobs).
- Address arithmetic is modulo 2^ADDR_W; base near the top wraps to 0.
- cnt width is $clog2(DEPTH+1).
- busy=1 exactly in CLEAR, REQ, WAIT, COMPUTE.

Optional Feature:
- Macro: MVM_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in REQ+WAIT for the current word and restarts on each REQ entry.
  - When the count reaches TIMEOUT_CYCLES, go to ERROR. avm_read drops immediately, no write enables are issued, err=1.
  - The watchdog is also active in COMPUTE (mac_done missing).
- Undefined: no counter; the block waits indefinitely; err is tied 0 and ERROR is unreachable.

Decomposition:
- Package mvm_pkg:
  - state enum mvm_seq_state_t.
  - default DATA_WIDTH/DEPTH constants.
  - function word_bits(DATA_WIDTH, DEPTH) returning the word width.
- One sub-module, mvm_watchdog (load/enable/expire counter), instantiated only under MVM_SEQ_TIMEOUT_EN.

Test Plan:
- Zero-wait memory, latency 1, base 0, DEPTH=8 -> one mac_clr pulse, then addresses 0..8 in order, 8 a_wren pulses, 1 b_wren on address 8, mac_done -> done=1, busy=0.
- waitrequest held 3 cycles on address 4 -> avm_read and avm_address=4 held stable for 4 cycles, no duplicate write enable, total enables still 9.
- base_addr=0xFFFF_FFFC -> addresses 0xFFFF_FFFC..0xFFFF_FFFF, then 0..4.
- rst_n=0 during WAIT at cnt=5, then a stray readdatavalid -> all outputs 0 after the reset edge, no a_wren, state IDLE; the next start runs a clean job from cnt=0.
- start pulsed in COMPUTE -> ignored; start in DONE -> new mac_clr, done deasserts on the CLEAR cycle.
- With MVM_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, readdatavalid never returned on address 2 -> err=1 after 16 cycles, avm_read=0, busy=0; without the macro -> stays busy in WAIT and err=0.
